// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with BEQ/BNE resolution.
// Non-branch instructions are held in a 2-entry skid buffer (head H drives
// out_*, skid S absorbs one extra instruction under backpressure).
// Branches are resolved from the ALU zero flag and never buffered.
// Optional feature macro: EX_MEM_FWD_EN (publishes H as an operand bypass).
`default_nettype none

module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic [RA_W-1:0]  rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic [WIDTH-1:0] br_target_in,
  input  logic [WIDTH-1:0] store_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_data
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store_data;
    logic [RA_W-1:0]  rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } entry_t;

  entry_t h_q, s_q, in_e;
  logic   h_vld, s_vld, h_vld_n, s_vld_n;
  logic   h_ld, s_ld, h_from_s;
  logic   is_br, accept, acc_nb, acc_br, pop, br_cond;

  assign in_e    = '{result: alu_out, store_data: store_data, rd: rd,
                     reg_write: reg_write, mem_read: mem_read, mem_write: mem_write};
  assign is_br   = is_beq | is_bne;
  assign accept  = in_valid & in_ready & ~flush;
  assign acc_nb  = accept & ~is_br;
  assign acc_br  = accept & is_br;
  assign pop     = h_vld & out_ready;
  assign br_cond = (is_beq & alu_zero) | (is_bne & ~alu_zero);

  // Skid-buffer steering: where the new entry lands and what the valid bits become.
  // flush wins over both pop and accept.
  always_comb begin
    h_vld_n  = h_vld;
    s_vld_n  = s_vld;
    h_ld     = 1'b0;
    s_ld     = 1'b0;
    h_from_s = 1'b0;
    if (flush) begin
      h_vld_n = 1'b0;
      s_vld_n = 1'b0;
    end else if (pop) begin
      if (s_vld) begin
        // S advances into H; in_ready was 0 so acc_nb is normally 0 here.
        h_from_s = 1'b1;
        s_ld     = acc_nb;
        s_vld_n  = acc_nb;
      end else begin
        h_ld    = acc_nb;
        h_vld_n = acc_nb;
      end
    end else if (acc_nb) begin
      if (!h_vld) begin
        h_ld    = 1'b1;
        h_vld_n = 1'b1;
      end else begin
        s_ld    = 1'b1;
        s_vld_n = 1'b1;
      end
    end
  end

  // Valid bits and registered ready; ready drops only when S holds an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld    <= 1'b0;
      s_vld    <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      h_vld    <= h_vld_n;
      s_vld    <= s_vld_n;
      in_ready <= ~s_vld_n;
    end
  end

  // Entry payloads; flush leaves data untouched, only valids are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      s_q <= '0;
    end else begin
      if (h_from_s)  h_q <= s_q;
      else if (h_ld) h_q <= in_e;
      if (s_ld)      s_q <= in_e;
    end
  end

  // Branch resolution: one-cycle pulse, target held between taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_taken <= acc_br & br_cond;
      if (acc_br && br_cond) br_target <= br_target_in;
    end
  end

  assign out_valid      = h_vld;
  assign out_result     = h_q.result;
  assign out_store_data = h_q.store_data;
  assign out_rd         = h_q.rd;
  assign out_reg_write  = h_q.reg_write;
  assign out_mem_read   = h_q.mem_read;
  assign out_mem_write  = h_q.mem_write;

`ifdef EX_MEM_FWD_EN
  // r0 writes are never forwarded since the regfile discards them.
  assign fwd_valid = h_vld & h_q.reg_write & (h_q.rd != '0);
  assign fwd_rd    = h_q.rd;
  assign fwd_data  = h_q.result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus with a queue scoreboard; a negedge
// monitor pops expected entries on every out handshake and every br_taken.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, is_beq, is_bne;
  logic [31:0] br_target_in, store_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, beq, bne, zero;
    logic [31:0] tgt;
  } op_t;

  op_t         q[$];
  logic [31:0] bq[$];

  ex_mem_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .is_beq(is_beq), .is_bne(is_bne),
    .br_target_in(br_target_in), .store_data(store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .br_taken(br_taken),
    .br_target(br_target), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_alu(input logic [31:0] res, input logic [4:0] r,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [31:0] sd);
    op_t o;
    o.res = res; o.sd = sd; o.rd = r; o.rw = rw; o.mr = mr; o.mw = mw;
    o.beq = 1'b0; o.bne = 1'b0; o.zero = (res == 32'd0); o.tgt = 32'hDEAD_BEEF;
    return o;
  endfunction

  function automatic op_t mk_br(input logic beq, input logic z, input logic [31:0] tgt);
    op_t o;
    o.res = z ? 32'd0 : 32'd5; o.sd = 32'd0; o.rd = 5'd0; o.rw = 1'b0;
    o.mr = 1'b0; o.mw = 1'b0; o.beq = beq; o.bne = ~beq; o.zero = z; o.tgt = tgt;
    return o;
  endfunction

  task automatic drive(input op_t o);
    alu_out = o.res; alu_zero = o.zero; rd = o.rd; reg_write = o.rw;
    mem_read = o.mr; mem_write = o.mw; is_beq = o.beq; is_bne = o.bne;
    br_target_in = o.tgt; store_data = o.sd;
  endtask

  // Present o until accepted; push its expected response when push is set.
  task automatic send(input op_t o, input bit push);
    int n;
    drive(o);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=in_ready0 want=in_ready1");
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      if (o.beq || o.bne) begin
        if ((o.beq && o.zero) || (o.bne && !o.zero)) bq.push_back(o.tgt);
      end else begin
        q.push_back(o);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: compare every delivered entry and every taken branch.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop got=%0h want=none", out_result);
      end else begin
        op_t e;
        logic        efv;
        logic [4:0]  erd;
        logic [31:0] efd;
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_store_data", out_store_data, e.sd);
        chk("out_rd", out_rd, e.rd);
        chk("out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, {e.rw, e.mr, e.mw});
`ifdef EX_MEM_FWD_EN
        efv = e.rw && (e.rd != 5'd0); erd = e.rd; efd = e.res;
`else
        efv = 1'b0; erd = 5'd0; efd = 32'd0;
`endif
        chk("fwd", {fwd_valid, fwd_rd, fwd_data}, {efv, erd, efd});
      end
    end
    if (rst_n && br_taken) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_br_taken got=%0h want=none", br_target);
      end else begin
        chk("br_target", br_target, bq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(mk_alu(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_out_data", {out_result, out_rd}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADD, one-cycle latency
    out_ready = 1'b1;
    send(mk_alu(32'h0000_0007, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0), 1);
    chk("add_latency_valid", out_valid, 1);
    chk("add_result", out_result, 32'h7);
    chk("add_rd", out_rd, 3);
`ifdef EX_MEM_FWD_EN
    chk("add_fwd_valid", fwd_valid, 1);
`else
    chk("add_fwd_valid", fwd_valid, 0);
`endif
    repeat (2) @(posedge clk); #1;

    // backpressure: two absorbed, ready drops, then drain in order
    out_ready = 1'b0;
    send(mk_alu(32'h0000_0100, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0), 1);
    send(mk_alu(32'h0000_0200, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0), 1);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_op0", out_result, 32'h100);
    repeat (2) @(posedge clk); #1;
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    send(mk_alu(32'h0000_0300, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0), 1);
    send(mk_alu(32'h0000_0400, 5'd4, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D), 1);
    repeat (3) @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);

    // branches
    send(mk_br(1'b1, 1'b1, 32'h0040_0020), 1);
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h0040_0020);
    chk("beq_no_out", out_valid, 0);
    @(posedge clk); #1;
    chk("beq_pulse_one_cycle", br_taken, 0);
    send(mk_br(1'b0, 1'b1, 32'h1111_2222), 1);
    chk("bne_not_taken", br_taken, 0);
    chk("br_target_hold", br_target, 32'h0040_0020);
    send(mk_br(1'b0, 1'b0, 32'h0000_0104), 1);
    chk("bne_taken", br_taken, 1);
    repeat (2) @(posedge clk); #1;

    // fill, then flush with an input present (ALU op, then a branch)
    out_ready = 1'b0;
    send(mk_alu(32'h0000_0A0A, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0), 0);
    send(mk_alu(32'h0000_0B0B, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0), 0);
    drive(mk_alu(32'h0000_0C0C, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0));
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(mk_br(1'b1, 1'b1, 32'h0BAD_0BAD));
    @(posedge clk); #1;
    chk("flush_br_dropped", br_taken, 0);
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("flush_nothing_left", out_valid, 0);

    // continuous pop+accept: S must stay empty
    for (int i = 0; i < 10; i++) begin
      send(mk_alu(32'h1000 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0, 32'h2000 + i), 1);
      chk("stream_in_ready", in_ready, 1);
    end
    repeat (3) @(posedge clk); #1;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(mk_alu(32'h0000_0D0D, 5'd13, 1'b1, 1'b0, 1'b0, 32'h0), 0);
    send(mk_br(1'b1, 1'b1, 32'h0000_0ABC), 0);
    chk("pre_rst_valid", {out_valid, br_taken}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_br_taken", br_taken, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    chk("sb_out_empty", q.size(), 0);
    chk("sb_br_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
